sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide DATA_W, 8, data width in bits (≥1).
REQ-002 SHALL provide DEPTH, 8, entry count; power of two, ≥2; AW = log2(DEPTH).
REQ-003 SHALL provide AF_LEVEL, DEPTH-2, almost_full threshold (1..DEPTH).
REQ-004 SHALL provide AE_LEVEL, 2, almost_empty threshold (0..DEPTH-1).
REQ-005 SHALL provide FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
Ports (name, direction, width, meaning):
REQ-006 SHALL provide clk, in, 1, single clock, rising edge.
REQ-007 SHALL provide reset, in, 1, synchronous reset, active-high.
REQ-008 SHALL provide write_en, in, 1, write request; read_en, in, 1, read request.
REQ-009 SHALL provide data_in, in, DATA_W, write data; out, out, DATA_W, read data.
REQ-010 SHALL provide out_valid, out, 1, out holds a valid popped or head word.
REQ-011 SHALL provide full, empty, almost_full, almost_empty, out, 1 each, status flags.
REQ-012 SHALL provide count, out, AW+1, current occupancy 0..DEPTH.
REQ-013 SHALL provide overflow, underflow, out, 1 each, sticky error flags; clr_err, in, 1, clears both.

Function
REQ-014 SHALL use AW+1-bit write and read pointers; storage is indexed by pointer[AW-1:0]; pointers wrap modulo 2*DEPTH.
REQ-015 SHALL assert empty when pointers are equal; full when MSBs differ and low AW bits are equal.
REQ-016 SHALL drive count = write pointer - read pointer (AW+1 bits, modulo); count, full, empty are derived from registered pointers only.
REQ-017 SHALL assert almost_full when count ≥ AF_LEVEL and almost_empty when count ≤ AE_LEVEL.
REQ-018 SHALL accept a write on a clk edge when write_en=1 and full=0: store data_in, increment write pointer.
REQ-019 SHALL accept a read on a clk edge when read_en=1 and empty=0: increment read pointer.
REQ-020 SHALL evaluate full/empty from pre-edge state: simultaneous write+read when full accepts only the read (count -1); when empty accepts only the write (count +1); otherwise both accepted, count unchanged.
REQ-021 SHALL, with FWFT=0, register the popped word into out on the accepting edge (1-cycle latency) and pulse out_valid high for exactly that following cycle; out holds its last value otherwise.
REQ-022 SHALL, with FWFT=1, present the head entry on out and drive out_valid = !empty; a word written into an empty FIFO appears on out the cycle after the write edge; read_en pops the displayed word.
REQ-023 SHALL set overflow on an edge with write_en=1 and full=1; set underflow on an edge with read_en=1 and empty=1; rejected requests change no pointer or storage.
REQ-024 SHALL clear overflow and underflow on an edge with clr_err=1; a set condition on the same edge takes priority over clear.
REQ-025 SHALL not let rejected writes corrupt stored data, including at pointer wrap-around.

Reset
REQ-026 SHALL, on an edge with reset=1, zero both pointers, out, out_valid, overflow, underflow; count=0, empty=1, full=0, almost_empty=1, almost_full=0.
REQ-027 SHALL give reset priority over all requests; reset mid-operation discards contents; storage array is not reset.

Verification (DATA_W=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-028 SHALL cover, FWFT=0: write 0x11..0x88 (8 writes) -> full=1, count=8, almost_full from count 6; 8 reads -> out 0x11..0x88 in order, each one cycle after read edge, empty=1.
REQ-029 SHALL cover: write when full (9th write 0x99) -> overflow=1, count stays 8, subsequent reads never return 0x99; clr_err -> overflow=0.
REQ-030 SHALL cover: read_en on empty after reset -> underflow=1, out_valid=0, out=0x00, count=0.
REQ-031 SHALL cover: simultaneous write+read at count=8 -> count 7; at count=0 -> count 1; at count=4 -> count 4, order preserved across 20 cycles with pointer wrap.
REQ-032 SHALL cover, FWFT=1: write 0xA5 into empty -> next cycle out=0xA5, out_valid=1 before any read; read -> empty=1, out_valid=0.
REQ-033 SHALL cover: reset asserted at count=5 -> next cycle count=0, empty=1, flags cleared; next write 0x3C is first word read back.

Source files
------------

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parameterised single-clock FIFO with registered or first-word-fall-through read
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_en,
  input  logic                       read_en,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       clr_err,
  output logic [DATA_W-1:0]          out,
  output logic                       out_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_AF = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] C_AE = (AW+1)'(AE_LEVEL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [DATA_W-1:0] r_out;
  logic              r_ovf;
  logic              r_udf;

  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [AW:0]       w_count;
  logic [DATA_W-1:0] w_head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_count  = r_wptr - r_rptr;
  assign w_wr_acc = write_en && !w_full;
  assign w_rd_acc = read_en && !w_empty;
  assign w_head   = r_mem[r_rptr[AW-1:0]];

  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = w_count;
  assign almost_full  = (w_count >= C_AF);
  assign almost_empty = (w_count <= C_AE);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

  always_ff @(posedge clk) begin
    if (!reset && w_wr_acc) begin
      r_mem[r_wptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // A fresh error on the same edge outranks clr_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (write_en && w_full) begin
        r_ovf <= 1'b1;
      end else if (clr_err) begin
        r_ovf <= 1'b0;
      end
      if (read_en && w_empty) begin
        r_udf <= 1'b1;
      end else if (clr_err) begin
        r_udf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
    end else if (w_rd_acc) begin
      r_out <= w_head;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown while occupied; last popped word is held when empty.
      assign out       = w_empty ? r_out : w_head;
      assign out_valid = !w_empty;
    end else begin : g_reg
      logic r_out_valid;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_out_valid <= 1'b0;
        end else begin
          r_out_valid <= w_rd_acc;
        end
      end
      assign out       = r_out;
      assign out_valid = r_out_valid;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed-vector bench for sync_fifo_param in registered and FWFT modes
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst0, we0, re0, clr0;
  logic [7:0] din0, out0;
  logic       ov0, full0, empty0, af0, ae0, ovf0, udf0;
  logic [3:0] cnt0;

  logic       rst1, we1, re1, clr1;
  logic [7:0] din1, out1;
  logic       ov1, full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0] cnt1;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_dut0 (
    .clk(clk), .reset(rst0), .write_en(we0), .read_en(re0), .data_in(din0), .clr_err(clr0),
    .out(out0), .out_valid(ov0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0));

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_dut1 (
    .clk(clk), .reset(rst1), .write_en(we1), .read_en(re1), .data_in(din1), .clr_err(clr1),
    .out(out1), .out_valid(ov1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1));

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1; we0 = 0; re0 = 0; clr0 = 0; din0 = 0;
    rst1 = 1; we1 = 0; re1 = 0; clr1 = 0; din1 = 0;
    tick;
    rst0 = 0; rst1 = 0;

    check_vec("rst_count", cnt0, 0);
    check_vec("rst_empty", empty0, 1);
    check_vec("rst_full", full0, 0);
    check_vec("rst_ae", ae0, 1);
    check_vec("rst_af", af0, 0);
    check_vec("rst_out", out0, 8'h00);
    check_vec("rst_out_valid", ov0, 0);
    check_vec("rst_ovf", ovf0, 0);
    check_vec("rst_udf", udf0, 0);
    check_vec("fwft_rst_valid", ov1, 0);
    check_vec("fwft_rst_empty", empty1, 1);

    re0 = 1; tick; re0 = 0;
    check_vec("udf_set", udf0, 1);
    check_vec("udf_out_valid", ov0, 0);
    check_vec("udf_out", out0, 8'h00);
    check_vec("udf_count", cnt0, 0);
    clr0 = 1; tick; clr0 = 0;
    check_vec("udf_clr", udf0, 0);

    for (int i = 0; i < 8; i++) begin
      we0 = 1; din0 = 8'h11 * (i + 1);
      tick;
      check_vec("fill_count", cnt0, i + 1);
      check_vec("fill_af", af0, (i + 1) >= 6);
      check_vec("fill_ae", ae0, (i + 1) <= 2);
    end
    check_vec("fill_full", full0, 1);

    din0 = 8'h99; tick; we0 = 0;
    check_vec("ovf_set", ovf0, 1);
    check_vec("ovf_count", cnt0, 8);
    check_vec("ovf_full", full0, 1);

    for (int i = 0; i < 8; i++) begin
      re0 = 1; tick;
      check_vec("drain_out", out0, 8'h11 * (i + 1));
      check_vec("drain_valid", ov0, 1);
      check_vec("drain_count", cnt0, 7 - i);
    end
    re0 = 0; tick;
    check_vec("drain_valid_drop", ov0, 0);
    check_vec("drain_out_hold", out0, 8'h88);
    check_vec("drain_empty", empty0, 1);
    clr0 = 1; tick; clr0 = 0;
    check_vec("ovf_clr", ovf0, 0);

    for (int i = 0; i < 8; i++) begin
      we0 = 1; din0 = 8'h40 + 8'(i); tick;
    end
    we0 = 0;
    check_vec("refill_full", full0, 1);
    we0 = 1; re0 = 1; din0 = 8'hEE; tick; we0 = 0;
    check_vec("wr_rd_full_count", cnt0, 7);
    check_vec("wr_rd_full_out", out0, 8'h40);
    for (int i = 1; i < 8; i++) begin
      tick;
      check_vec("wr_rd_full_order", out0, 8'h40 + 8'(i));
    end
    re0 = 0;
    check_vec("wr_rd_full_empty", cnt0, 0);

    we0 = 1; re0 = 1; din0 = 8'h5A; tick; we0 = 0; re0 = 0;
    check_vec("wr_rd_empty_count", cnt0, 1);
    check_vec("wr_rd_empty_valid", ov0, 0);
    check_vec("wr_rd_empty_udf", udf0, 1);
    clr0 = 1; tick; clr0 = 0;
    re0 = 1; tick; re0 = 0;
    check_vec("wr_rd_empty_out", out0, 8'h5A);
    check_vec("wr_rd_empty_drain", cnt0, 0);

    for (int i = 0; i < 4; i++) begin
      we0 = 1; din0 = 8'h70 + 8'(i); q.push_back(din0); tick;
    end
    for (int k = 0; k < 20; k++) begin
      we0 = 1; re0 = 1; din0 = 8'h80 + 8'(k); q.push_back(din0);
      tick;
      exp_d = q.pop_front();
      check_vec("steady_out", out0, exp_d);
      check_vec("steady_count", cnt0, 4);
    end
    we0 = 0; re0 = 0;

    clr0 = 1; tick; clr0 = 0;
    q.delete();
    re0 = 1;
    for (int i = 0; i < 4; i++) tick;
    tick; re0 = 0;
    check_vec("pre_rst_udf", udf0, 1);
    for (int i = 0; i < 5; i++) begin
      we0 = 1; din0 = 8'h01 + 8'(i); tick;
    end
    we0 = 0;
    check_vec("pre_rst_count", cnt0, 5);
    rst0 = 1; tick; rst0 = 0;
    check_vec("mid_rst_count", cnt0, 0);
    check_vec("mid_rst_empty", empty0, 1);
    check_vec("mid_rst_udf", udf0, 0);
    check_vec("mid_rst_ae", ae0, 1);
    check_vec("mid_rst_out", out0, 8'h00);
    check_vec("mid_rst_valid", ov0, 0);
    we0 = 1; din0 = 8'h3C; tick; we0 = 0;
    re0 = 1; tick; re0 = 0;
    check_vec("post_rst_out", out0, 8'h3C);
    check_vec("post_rst_valid", ov0, 1);

    we1 = 1; din1 = 8'hA5; tick; we1 = 0;
    check_vec("fwft_out", out1, 8'hA5);
    check_vec("fwft_valid", ov1, 1);
    tick;
    check_vec("fwft_hold", out1, 8'hA5);
    re1 = 1; tick; re1 = 0;
    check_vec("fwft_pop_empty", empty1, 1);
    check_vec("fwft_pop_valid", ov1, 0);
    we1 = 1; din1 = 8'hB1; tick; din1 = 8'hB2; tick; we1 = 0;
    check_vec("fwft_head", out1, 8'hB1);
    re1 = 1; tick;
    check_vec("fwft_next", out1, 8'hB2);
    check_vec("fwft_next_count", cnt1, 1);
    tick; re1 = 0;
    check_vec("fwft_final_empty", empty1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
